// File: rtl/softmax_pkg.sv
// Shared definitions for the softmax max-finder: FSM state encoding and the
// most-negative-score helper.
package softmax_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Returns a 64-bit word with only bit (width-1) set; the low 'width' bits
    // are the most-negative two's-complement value of that width.
    function automatic logic [63:0] most_neg(input int width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/softmax_cmp.sv
// Signed compare-and-select: the candidate wins only when strictly greater, so
// ties keep the earlier (current) value. Index ports exist with SOFTMAX_MAX_IDX_EN.
module softmax_cmp #(
    parameter int DATA_WIDTH = 16,
    parameter int IDX_WIDTH  = 4
) (
    input  logic signed [DATA_WIDTH-1:0] cand,
    input  logic signed [DATA_WIDTH-1:0] cur_max,
    output logic signed [DATA_WIDTH-1:0] sel_max
`ifdef SOFTMAX_MAX_IDX_EN
    ,
    input  logic [IDX_WIDTH-1:0]         cand_idx,
    input  logic [IDX_WIDTH-1:0]         cur_idx,
    output logic [IDX_WIDTH-1:0]         sel_idx
`endif
);

    logic take_cand;

    assign take_cand = (cand > cur_max);
    assign sel_max   = take_cand ? cand : cur_max;

`ifdef SOFTMAX_MAX_IDX_EN
    assign sel_idx   = take_cand ? cand_idx : cur_idx;
`endif

endmodule

// File: rtl/softmax_max_finder.sv
// Streams NUM_CLASS signed scores per frame and writes the frame maximum to the
// downstream softmax register. Define SOFTMAX_MAX_IDX_EN to add the max_idx output.
module softmax_max_finder
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_CLASS  = 10,
    parameter int IDX_WIDTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    output logic                         ready_in,
    output logic                         reg_write,
    output logic signed [DATA_WIDTH-1:0] max_out,
    output logic                         done,
    output logic                         busy
`ifdef SOFTMAX_MAX_IDX_EN
    ,
    output logic [IDX_WIDTH-1:0]         max_idx
`endif
);

    localparam logic [63:0]                  MIN_FULL = most_neg(DATA_WIDTH);
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL  = MIN_FULL[DATA_WIDTH-1:0];
    localparam logic [IDX_WIDTH-1:0]         LAST_IDX = IDX_WIDTH'(NUM_CLASS - 1);

    state_e                         state_q, state_d;
    logic [IDX_WIDTH-1:0]           count_q, count_d;
    logic signed [DATA_WIDTH-1:0]   run_max_q, run_max_d;
    logic signed [DATA_WIDTH-1:0]   max_out_q, max_out_d;
    logic signed [DATA_WIDTH-1:0]   sel_max;

`ifdef SOFTMAX_MAX_IDX_EN
    logic [IDX_WIDTH-1:0]           run_idx_q, run_idx_d;
    logic [IDX_WIDTH-1:0]           max_idx_q, max_idx_d;
    logic [IDX_WIDTH-1:0]           sel_idx;
`endif

    softmax_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_cmp (
        .cand     (data_in),
        .cur_max  (run_max_q),
        .sel_max  (sel_max)
`ifdef SOFTMAX_MAX_IDX_EN
        ,
        .cand_idx (count_q),
        .cur_idx  (run_idx_q),
        .sel_idx  (sel_idx)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            run_max_q <= '0;
            max_out_q <= '0;
`ifdef SOFTMAX_MAX_IDX_EN
            run_idx_q <= '0;
            max_idx_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            run_max_q <= run_max_d;
            max_out_q <= max_out_d;
`ifdef SOFTMAX_MAX_IDX_EN
            run_idx_q <= run_idx_d;
            max_idx_q <= max_idx_d;
`endif
        end
    end

    // The published result is loaded on the final accept so it is already
    // stable during the single WRITE cycle and held through IDLE afterwards.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        run_max_d = run_max_q;
        max_out_d = max_out_q;
`ifdef SOFTMAX_MAX_IDX_EN
        run_idx_d = run_idx_q;
        max_idx_d = max_idx_q;
`endif
        ready_in  = 1'b0;
        reg_write = 1'b0;
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_SCAN;
                    count_d   = '0;
                    run_max_d = MIN_VAL;
`ifdef SOFTMAX_MAX_IDX_EN
                    run_idx_d = '0;
`endif
                end
            end
            ST_SCAN: begin
                ready_in = 1'b1;
                if (valid_in) begin
                    run_max_d = sel_max;
                    count_d   = count_q + IDX_WIDTH'(1);
`ifdef SOFTMAX_MAX_IDX_EN
                    run_idx_d = sel_idx;
`endif
                    if (count_q == LAST_IDX) begin
                        state_d   = ST_WRITE;
                        count_d   = '0;
                        max_out_d = sel_max;
`ifdef SOFTMAX_MAX_IDX_EN
                        max_idx_d = sel_idx;
`endif
                    end
                end
            end
            ST_WRITE: begin
                reg_write = 1'b1;
                done      = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign max_out = max_out_q;
`ifdef SOFTMAX_MAX_IDX_EN
    assign max_idx = max_idx_q;
`endif

endmodule

// File: tb/tb_softmax_max_finder.sv
// Directed bench for softmax_max_finder: frames with hand-computed maxima,
// stalls, ignored start/valid, and asynchronous reset mid-frame.
module tb_softmax_max_finder;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               valid_in;
    logic signed [15:0] data_in;
    logic               ready_in;
    logic               reg_write;
    logic signed [15:0] max_out;
    logic               done;
    logic               busy;
`ifdef SOFTMAX_MAX_IDX_EN
    logic [3:0]         max_idx;
`endif

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;

    logic signed [15:0] sc_a   [10];
    logic signed [15:0] sc_min [10];
    logic signed [15:0] sc_ramp[10];
    logic signed [15:0] sc_one [10];

    softmax_max_finder #(
        .DATA_WIDTH (16),
        .NUM_CLASS  (10),
        .IDX_WIDTH  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .ready_in  (ready_in),
        .reg_write (reg_write),
        .max_out   (max_out),
        .done      (done),
        .busy      (busy)
`ifdef SOFTMAX_MAX_IDX_EN
        ,
        .max_idx   (max_idx)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reg_write) wr_count <= wr_count + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drives one full frame; returns to IDLE with inputs quiet.
    task automatic run_frame(input string name,
                             input logic signed [15:0] sc [10],
                             input bit gaps, input bit hold_start,
                             input bit already_started,
                             input logic signed [15:0] exp_max,
                             input int exp_idx);
        int w0;
        w0 = wr_count;
        if (!already_started) begin
            start = 1'b1;
            tick();
        end
        start = hold_start;
        check({name, "_busy_start"}, busy, 1);
        check({name, "_ready_scan"}, ready_in, 1);
        for (int i = 0; i < 10; i++) begin
            if (gaps) begin
                valid_in = 1'b0;
                data_in  = 16'sh7fff;
                tick();
                check({name, "_stall_ready"}, ready_in, 1);
                check({name, "_stall_nowr"}, reg_write, 0);
            end
            valid_in = 1'b1;
            data_in  = sc[i];
            tick();
            if (i < 9) begin
                check({name, "_early_wr"}, reg_write, 0);
            end
        end
        valid_in = 1'b0;
        check({name, "_reg_write"}, reg_write, 1);
        check({name, "_done"}, done, 1);
        check({name, "_ready_write"}, ready_in, 0);
        check({name, "_max_out"}, max_out, exp_max);
`ifdef SOFTMAX_MAX_IDX_EN
        check({name, "_max_idx"}, {28'd0, max_idx}, exp_idx);
`else
        if (exp_idx < 0) check({name, "_idx_arg"}, exp_idx, 0);
`endif
        tick();
        start = 1'b0;
        check({name, "_wr_end"}, reg_write, 0);
        check({name, "_busy_end"}, busy, 0);
        check({name, "_max_hold"}, max_out, exp_max);
        check({name, "_wr_count"}, wr_count - w0, 1);
    endtask

    initial begin
        sc_a    = '{16'sd3, -16'sd7, 16'sd12, 16'sd5, 16'sd12,
                    16'sd0, -16'sd1, 16'sd9, 16'sd2, 16'sd4};
        sc_min  = '{default: 16'sh8000};
        sc_ramp = '{16'sd0, 16'sd1, 16'sd2, 16'sd3, 16'sd4,
                    16'sd5, 16'sd6, 16'sd7, 16'sd8, 16'sd9};
        sc_one  = '{default: 16'sd1};

        rst_n    = 1'b0;
        start    = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_ready", ready_in, 0);
        check("rst_wr", reg_write, 0);
        check("rst_done", done, 0);
        check("rst_max", max_out, 0);
        tick();
        rst_n = 1'b1;

        // valid_in in IDLE must be ignored
        valid_in = 1'b1;
        data_in  = 16'sd500;
        tick();
        tick();
        valid_in = 1'b0;
        check("idle_valid_busy", busy, 0);
        check("idle_valid_ready", ready_in, 0);
        check("idle_valid_max", max_out, 0);
        check("idle_valid_wr", wr_count, 0);

        run_frame("tie", sc_a, 1'b0, 1'b0, 1'b0, 16'sd12, 2);
        run_frame("allmin", sc_min, 1'b0, 1'b0, 1'b0, 16'sh8000, 0);
        run_frame("gaps", sc_ramp, 1'b1, 1'b0, 1'b0, 16'sd9, 9);

        // Result must hold in IDLE while valid_in carries junk
        valid_in = 1'b1;
        data_in  = 16'sd1000;
        tick();
        tick();
        valid_in = 1'b0;
        check("hold_max", max_out, 9);
        check("hold_wr", wr_count, 3);

        // Start held high through the frame has no extra effect
        run_frame("restart", sc_a, 1'b0, 1'b1, 1'b0, 16'sd12, 2);
        check("restart_total_wr", wr_count, 4);

        // Reset mid-frame after 4 scores
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1;
            data_in  = 16'sd50;
            tick();
        end
        valid_in = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_ready", ready_in, 0);
        check("async_rst_max", max_out, 0);
        tick();
        tick();
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        check("post_rst_first_start", busy, 1);
        check("post_rst_no_wr", wr_count, 4);
        run_frame("ones", sc_one, 1'b0, 1'b0, 1'b1, 16'sd1, 0);
        check("final_total_wr", wr_count, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/softmax_max_finder.md
SOFTMAX_MAX_FINDER -- requirements
Module: softmax_max_finder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of each signed score and of the max result.
REQ-002 SHALL have parameter NUM_CLASS, default 10, number of scores per frame (2..255).
REQ-003 SHALL have parameter IDX_WIDTH, default 4, width of the class index (>= clog2(NUM_CLASS)).
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-007 SHALL have port valid_in  input  1  data_in carries a score this cycle.
REQ-008 SHALL have port data_in  input  DATA_WIDTH  signed two's-complement score.
REQ-009 SHALL have port ready_in  output  1  block accepts a score this cycle.
REQ-010 SHALL have port reg_write  output  1  one-cycle write strobe to the downstream softmax holding register.
REQ-011 SHALL have port max_out  output  DATA_WIDTH  frame maximum, drives the downstream register data input.
REQ-012 SHALL have port done  output  1  one-cycle pulse, frame complete, coincident with reg_write.
REQ-013 SHALL have port busy  output  1  high from accepted start until done inclusive.

Function
REQ-014 SHALL implement FSM states IDLE, SCAN, WRITE.
REQ-015 IDLE -> SCAN on start=1; running max preset to most-negative DATA_WIDTH value, count cleared to 0.
REQ-016 start SHALL be ignored in SCAN and WRITE.
REQ-017 ready_in SHALL be 1 only in SCAN; a score is accepted when valid_in & ready_in.
REQ-018 Each accepted score SHALL replace the running max only if strictly greater (signed compare); ties keep the earlier value.
REQ-019 Count SHALL increment per accepted score; on acceptance with count = NUM_CLASS-1, SCAN -> WRITE.
REQ-020 valid_in gaps in SCAN SHALL stall with no state change; no timeout.
REQ-021 In WRITE, reg_write and done SHALL be 1 for exactly one cycle with max_out stable; WRITE -> IDLE next cycle.
REQ-022 Latency SHALL be exactly 1 cycle from the last accepted score to reg_write.
REQ-023 max_out SHALL hold its last frame value in IDLE until the next frame's WRITE updates it.
REQ-024 valid_in while in IDLE or WRITE SHALL be ignored.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, count 0, max_out 0, ready_in 0, reg_write 0, done 0, busy 0, regardless of clk.
REQ-026 Reset asserted mid-frame SHALL discard the partial frame; no reg_write SHALL follow its release.
REQ-027 First start SHALL be honoured on the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro SOFTMAX_MAX_IDX_EN SHALL, when defined, add output max_idx (IDX_WIDTH) giving the 0-based position of max_out, updated with it, reset to 0.
REQ-029 Without SOFTMAX_MAX_IDX_EN, port max_idx and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-030 FSM state encoding and the most-negative-value constant function SHALL live in shared package softmax_pkg.
REQ-031 Signed compare-and-select SHALL be sub-module softmax_cmp (inputs: candidate, current max, optional indices; outputs: selected max/index).

Verification
REQ-032 Scores 3,-7,12,5,12,0,-1,9,2,4 -> reg_write pulse, max_out=12, max_idx=2 (tie keeps first), done 1 cycle after 10th accept.
REQ-033 All ten scores -32768 -> max_out=-32768, max_idx=0.
REQ-034 valid_in toggled every other cycle, scores 0..9 -> max_out=9, max_idx=9, exactly one reg_write.
REQ-035 rst_n pulsed low after 4th score, then new frame of all 1 -> no stray write, single write max_out=1.
REQ-036 start re-asserted during SCAN and valid_in in IDLE -> no effect; frame count and result unchanged.
